ps2_scancode_sequencer: RTL and testbench



---
 rtl/ps2_scancode_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ps2_scancode_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_sequencer.sv
// Turns the PS/2 set-2 byte stream into {ext, brk, code} key events, tracks
// shift/caps-lock, and queues events in a show-ahead FIFO for the consumer.
module ps2_scancode_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_strb,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       seq_abort
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          expire;
  logic          emit, emit_ext, emit_brk, abort_next;
  logic          lshift, rshift, caps_down;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          pop, push_ok, drop;
  logic [9:0]    head;

  assign expire = (state != IDLE) && (timer == TIMER_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seq_abort <= 1'b0;
    end else begin
      state     <= state_next;
      seq_abort <= abort_next;
    end
  end

  // A strobe always takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    abort_next = 1'b0;
    if (rx_strb) begin
      if (rx_data == 8'h00 || rx_data == 8'hFF) begin
        state_next = IDLE;
        abort_next = (state != IDLE);
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_data == 8'hE0)      state_next = EXT;
            else if (rx_data == 8'hF0) state_next = BRK;
            else                       emit = 1'b1;
          end
          EXT: begin
            if (rx_data == 8'hF0) state_next = EXT_BRK;
            else if (rx_data != 8'hE0) begin
              emit       = 1'b1;
              emit_ext   = 1'b1;
              state_next = IDLE;
            end
          end
          BRK, EXT_BRK: begin
            state_next = IDLE;
            if (rx_data == 8'hE0 || rx_data == 8'hF0) begin
              abort_next = 1'b1;
            end else begin
              emit     = 1'b1;
              emit_ext = (state == EXT_BRK);
              emit_brk = 1'b1;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (expire) begin
      state_next = IDLE;
      abort_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               timer <= '0;
    else if (rx_strb || state == IDLE || expire) timer <= '0;
    else                                      timer <= timer + 1'b1;
  end

  // Modifiers follow every emitted non-extended event, even ones the FIFO drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_down <= 1'b0;
      caps_lock <= 1'b0;
    end else if (emit && !emit_ext) begin
      if (rx_data == 8'h12) lshift <= !emit_brk;
      if (rx_data == 8'h59) rshift <= !emit_brk;
      if (rx_data == 8'h58) begin
        if (emit_brk) begin
          caps_down <= 1'b0;
        end else if (!caps_down) begin
          caps_down <= 1'b1;
          caps_lock <= !caps_lock;
        end
      end
    end
  end

  assign shift_held = lshift | rshift;

  assign pop     = evt_ready && (count != '0);
  assign push_ok = emit && ((count < FULL_COUNT) || pop);
  assign drop    = emit && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {emit_ext, emit_brk, rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    evt_valid = (count != '0);
    evt_code  = 8'h00;
    evt_ext   = 1'b0;
    evt_break = 1'b0;
    if (evt_valid) begin
      evt_code  = head[7:0];
      evt_ext   = head[9];
      evt_break = head[8];
    end
  end

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench: stimulus pushes expected events into a queue, a monitor
// pops and compares whenever the DUT hands over an event.
module tb_ps2_scancode_sequencer;

  localparam int T     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strb = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_valid;
  logic       evt_ready = 1'b0;
  logic       shift_held, caps_lock, overflow;
  logic       clr_overflow = 1'b0;
  logic       seq_abort;

  int errors = 0;
  int checks = 0;
  int abort_cnt = 0;
  int abort_base;
  logic [9:0] exp_q[$];

  ps2_scancode_sequencer #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_strb(rx_strb),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .shift_held(shift_held),
    .caps_lock(caps_lock), .overflow(overflow), .clr_overflow(clr_overflow),
    .seq_abort(seq_abort)
  );

  always #5 clk = ~clk;

  // Monitor: sample on the falling edge, compare each handed-over event.
  always @(negedge clk) begin
    logic [9:0] got, want;
    if (rst_n) begin
      if (seq_abort) abort_cnt++;
      if (evt_valid && evt_ready) begin
        got = {evt_ext, evt_break, evt_code};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event: got %03h, none expected", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("[TB] FAIL event: got %03h expected %03h", got, want);
          end
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data = b;
    rx_strb = 1'b1;
    @(posedge clk);
    #1;
    rx_strb = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic expectEvent(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) checkOutput({name, "_drain_timeout"}, exp_q.size(), 0);
    checkOutput({name, "_valid_after_drain"}, int'(evt_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #12;
    checkOutput("reset_valid", int'(evt_valid), 0);
    checkOutput("reset_code", int'(evt_code), 0);
    checkOutput("reset_ext_brk", int'({evt_ext, evt_break}), 0);
    checkOutput("reset_mods", int'({shift_held, caps_lock}), 0);
    checkOutput("reset_ovf_abort", int'({overflow, seq_abort}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(1);

    // Four event kinds queued, then drained in order.
    evt_ready = 1'b0;
    applyStimulus(8'h1C);                       expectEvent(0, 0, 8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C); expectEvent(0, 1, 8'h1C);
    applyStimulus(8'hE0); applyStimulus(8'h75); expectEvent(1, 0, 8'h75);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    expectEvent(1, 1, 8'h75);
    checkOutput("head_valid", int'(evt_valid), 1);
    checkOutput("head_code", int'(evt_code), 'h1C);
    drain("kinds");

    // Shift and caps-lock tracking including a typematic repeat.
    applyStimulus(8'h12); expectEvent(0, 0, 8'h12);
    checkOutput("shift_set", int'(shift_held), 1);
    applyStimulus(8'h58); expectEvent(0, 0, 8'h58);
    checkOutput("caps_on", int'(caps_lock), 1);
    applyStimulus(8'h58); expectEvent(0, 0, 8'h58);
    checkOutput("caps_repeat", int'(caps_lock), 1);
    applyStimulus(8'hF0); applyStimulus(8'h58); expectEvent(0, 1, 8'h58);
    checkOutput("caps_release", int'(caps_lock), 1);
    applyStimulus(8'h58); expectEvent(0, 0, 8'h58);
    checkOutput("caps_off", int'(caps_lock), 0);
    applyStimulus(8'hE0); applyStimulus(8'h12); expectEvent(1, 0, 8'h12);
    applyStimulus(8'hF0); applyStimulus(8'h12); expectEvent(0, 1, 8'h12);
    checkOutput("shift_clear", int'(shift_held), 0);
    drain("mods");

    // Watchdog expiry abandons a break prefix.
    abort_base = abort_cnt;
    applyStimulus(8'hF0);
    waitCycles(T + 2);
    checkOutput("timeout_abort", abort_cnt - abort_base, 1);
    applyStimulus(8'h1C); expectEvent(0, 0, 8'h1C);
    drain("timeout");

    // A byte arriving in the expiry cycle wins over the watchdog.
    abort_base = abort_cnt;
    applyStimulus(8'hF0);
    waitCycles(T - 1);
    applyStimulus(8'h1C); expectEvent(0, 1, 8'h1C);
    waitCycles(2);
    checkOutput("expiry_byte_wins", abort_cnt - abort_base, 0);
    drain("expiry");

    // Overflow, clear, clear-vs-drop priority, push with pop at full.
    evt_ready = 1'b0;
    applyStimulus(8'h15); expectEvent(0, 0, 8'h15);
    applyStimulus(8'h16); expectEvent(0, 0, 8'h16);
    applyStimulus(8'h1E); expectEvent(0, 0, 8'h1E);
    applyStimulus(8'h26); expectEvent(0, 0, 8'h26);
    checkOutput("no_ovf_at_full", int'(overflow), 0);
    applyStimulus(8'h25);
    checkOutput("ovf_set", int'(overflow), 1);
    checkOutput("full_head", int'(evt_code), 'h15);
    clr_overflow = 1'b1; waitCycles(1); clr_overflow = 1'b0;
    checkOutput("ovf_cleared", int'(overflow), 0);
    clr_overflow = 1'b1; applyStimulus(8'h4D); clr_overflow = 1'b0;
    checkOutput("clr_loses_to_drop", int'(overflow), 1);
    clr_overflow = 1'b1; waitCycles(1); clr_overflow = 1'b0;
    evt_ready = 1'b1;
    applyStimulus(8'h2E); expectEvent(0, 0, 8'h2E);
    checkOutput("push_pop_at_full", int'(overflow), 0);
    drain("overflow");

    // Protocol errors and error bytes.
    abort_base = abort_cnt;
    applyStimulus(8'hF0); applyStimulus(8'hE0);
    waitCycles(2);
    checkOutput("abort_F0E0", abort_cnt - abort_base, 1);
    checkOutput("no_event_F0E0", int'(evt_valid), 0);
    abort_base = abort_cnt;
    applyStimulus(8'h00);
    waitCycles(2);
    checkOutput("idle_00_silent", abort_cnt - abort_base, 0);
    applyStimulus(8'hE0); applyStimulus(8'h00);
    waitCycles(2);
    checkOutput("abort_00_ext", abort_cnt - abort_base, 1);
    applyStimulus(8'h29); expectEvent(0, 0, 8'h29);
    drain("errors");

    // Reset mid-sequence with events queued.
    evt_ready = 1'b0;
    applyStimulus(8'h1C); expectEvent(0, 0, 8'h1C);
    applyStimulus(8'h32); expectEvent(0, 0, 8'h32);
    applyStimulus(8'hE0);
    checkOutput("queued_before_reset", int'(evt_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_flush_valid", int'(evt_valid), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(1);
    evt_ready = 1'b1;
    applyStimulus(8'h1C); expectEvent(0, 0, 8'h1C);
    drain("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
